gf7_inverter_seq: RTL and testbench
===================================

# gf7_inverter_seq

Sequential multiplicative inverter over GF(2^7). It computes a⁻¹ = a^126 with an Itoh–Tsujii style addition chain built on a single shared multiplier. It sits directly upstream of the point adder: it takes the slope denominator (x1 ⊕ x2) and supplies the inverse that the adder's combinational slope, x3 and y3 logic consumes. A start/done handshake replaces the bare load strobe, so the controller knows exactly when the point sum is valid.

## Interface
Parameters:
- FIELD_W, default 7: field element width; only 7 is supported.
- FIELD_POLY, default 8'h83: irreducible polynomial x^7+x+1. It is identical to the polynomial hard-wired in Mastrovito7.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- reset_n  input  1  reset, synchronous and active-low.
- start  input  1  single-cycle request; samples a_in. Honoured only in IDLE or DONE.
- a_in  input  7  element to invert (slope denominator).
- busy  output  1  high while a computation is in flight.
- done  output  1  one-cycle pulse; inv_out and zero_div are valid from this cycle on.
- inv_out  output  7  a_in⁻¹. Held until the next accepted start or reset.
- zero_div  output  1  high with done when a_in was 0 (P1.x == P2.x: doubling or P + (−P)). inv_out is then 0.

## Operation
- Addition chain: r ← a; repeat 5×: { t ← r·r ; r ← t·a }, giving a^3, a^7, a^15, a^31, a^63; then a final r ← r·r = a^126 = a⁻¹.
- One Mastrovito7 instance is time-multiplexed. Operand muxes select (r, r) in square cycles and (t, a_reg) in multiply cycles.
- States:
  - IDLE: start → SQ. Load a_reg ← a_in and r ← a_in; clear step.
  - SQ: t ← r·r → MUL.
  - MUL: r ← t·a_reg. If step == 4 → FSQ; otherwise step++ and → SQ.
  - FSQ: inv_out ← r·r; zero_div ← (a_reg == 0) → DONE.
  - DONE: done = 1. start → SQ (back-to-back accepted); otherwise → IDLE.
- step is a 3-bit counter, 0..4; it never wraps past 4.
- Zero input needs no special path: the chain yields 0 naturally. zero_div is derived from a_reg only.
- start in SQ, MUL or FSQ is ignored. a_reg is not reloaded and no error is flagged.
- a_in changing after the accepting edge has no effect, because a_reg holds the operand.

## Timing
- Accepting edge is E0. States: SQ/MUL pairs on E1..E10, FSQ on E11.
- done is high in the cycle after E11: fixed latency of 11 cycles, start to done, for every input including 0.
- busy is high in SQ, MUL and FSQ (11 cycles). It is low in IDLE and DONE, so busy and done are never both high.
- Minimum issue interval is 12 cycles when start is asserted in the DONE cycle.
- inv_out and zero_div update only at the FSQ edge and are stable for the point adder from done onward.
- Reset values (reset_n low at an edge): state IDLE, busy 0, done 0, inv_out 0, zero_div 0, step 0, a_reg/r/t 0.
- Reset mid-computation aborts with no done pulse. start in the same cycle as active reset is ignored.

## Structure
- Package ec_gf_pkg holds:
  - FIELD_W and FIELD_POLY
  - the point width constant (2·FIELD_W = 14) and {y, x} field offsets shared with the point adder
  - the inverter state enum (IDLE, SQ, MUL, FSQ, DONE)
  - the step terminal count (4)
- Sub-module: reuse the existing Mastrovito7 unmodified, instanced once. Do not create a separate squarer.
- The point adder is updated to take inv_out and gate its result with done. That change is out of this block's scope.

## Test plan
- a_in=0x01 → done exactly 11 cycles after start, inv_out=0x01, zero_div=0. Check busy high for exactly 11 cycles.
- a_in=0x02 → inv_out=0x41. a_in=0x41 → 0x02. a_in=0x04 → 0x61.
- a_in=0x00 → done at cycle 11, inv_out=0x00, zero_div=1.
- Exhaustive sweep of all 127 nonzero a_in, issued back-to-back via start in each DONE cycle → each done spaced 12 cycles, and inv_out·a_in=1 checked against a reference GF(2^7) model.
- Extra start pulses in cycles 3 and 10 of a run with a_in=0x04 → ignored; result still 0x61 at cycle 11, no extra done.
- reset_n low in cycle 5 of a run → next cycle busy=0, inv_out=0, no done pulse. A fresh start with 0x02 then yields 0x41 after 11 cycles.

Source files
------------

// File: rtl/ec_gf_pkg.sv
// Shared GF(2^7) constants and types for the inverter and the point adder.
package ec_gf_pkg;

  localparam int unsigned FIELD_W    = 7;
  localparam logic [7:0]  FIELD_POLY = 8'h83;

  // Point vector layout {y, x} as seen by the point adder
  localparam int unsigned POINT_W  = 2 * FIELD_W;
  localparam int unsigned PT_X_LSB = 0;
  localparam int unsigned PT_Y_LSB = FIELD_W;

  typedef enum logic [2:0] {
    INV_IDLE,
    INV_SQ,
    INV_MUL,
    INV_FSQ,
    INV_DONE
  } inv_state_e;

  localparam logic [2:0] STEP_LAST = 3'd4;

endpackage

// File: rtl/Mastrovito7.sv
// Combinational GF(2^7) multiplier, reduction polynomial x^7+x+1 hard-wired.
module Mastrovito7 (
  input  logic [6:0] a,
  input  logic [6:0] b,
  output logic [6:0] p
);

  logic [6:0] acc;
  logic [6:0] col;

  // col walks the Mastrovito matrix columns a*x^j mod f(x)
  always_comb begin
    acc = '0;
    col = a;
    for (int unsigned j = 0; j < 7; j++) begin
      if (b[j]) acc = acc ^ col;
      col = {col[5:0], 1'b0} ^ (col[6] ? 7'h03 : 7'h00);
    end
    p = acc;
  end

endmodule

// File: rtl/gf7_inverter_seq.sv
// Sequential GF(2^7) inverter: a^-1 = a^126 via an Itoh-Tsujii chain on one
// time-shared multiplier, with start/done handshake toward the point adder.
module gf7_inverter_seq
  import ec_gf_pkg::*;
#(
  parameter int unsigned FIELD_W    = ec_gf_pkg::FIELD_W,
  parameter logic [7:0]  FIELD_POLY = ec_gf_pkg::FIELD_POLY
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [FIELD_W-1:0] a_in,
  output logic               busy,
  output logic               done,
  output logic [FIELD_W-1:0] inv_out,
  output logic               zero_div
);

  if (FIELD_W != 7 || FIELD_POLY != 8'h83) begin : g_bad_cfg
    $error("gf7_inverter_seq supports only FIELD_W=7, FIELD_POLY=8'h83");
  end

  inv_state_e         state;
  logic [FIELD_W-1:0] a_reg;
  logic [FIELD_W-1:0] r;
  logic [FIELD_W-1:0] t;
  logic [2:0]         step;
  logic [FIELD_W-1:0] op_a;
  logic [FIELD_W-1:0] op_b;
  logic [FIELD_W-1:0] prod;
  logic               accept;

  // Square cycles (SQ, FSQ) feed (r, r); multiply cycles feed (t, a_reg)
  always_comb begin
    op_a = (state == INV_MUL) ? t     : r;
    op_b = (state == INV_MUL) ? a_reg : r;
  end

  Mastrovito7 u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  assign accept = start && (state == INV_IDLE || state == INV_DONE);
  assign busy   = (state == INV_SQ) || (state == INV_MUL) || (state == INV_FSQ);
  assign done   = (state == INV_DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= INV_IDLE;
      a_reg    <= '0;
      r        <= '0;
      t        <= '0;
      step     <= '0;
      inv_out  <= '0;
      zero_div <= 1'b0;
    end else begin
      case (state)
        INV_IDLE, INV_DONE: begin
          if (accept) begin
            a_reg <= a_in;
            r     <= a_in;
            step  <= '0;
            state <= INV_SQ;
          end else begin
            state <= INV_IDLE;
          end
        end
        INV_SQ: begin
          t     <= prod;
          state <= INV_MUL;
        end
        INV_MUL: begin
          r <= prod;
          if (step == STEP_LAST) begin
            state <= INV_FSQ;
          end else begin
            step  <= step + 3'd1;
            state <= INV_SQ;
          end
        end
        INV_FSQ: begin
          inv_out  <= prod;
          zero_div <= (a_reg == '0);
          state    <= INV_DONE;
        end
        default: state <= INV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf7_inverter_seq.sv
// Directed bench for gf7_inverter_seq: vector table, back-to-back sweep,
// ignored-start and mid-run reset sequences.
module tb_gf7_inverter_seq;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       start    = 1'b0;
  logic [6:0] a_in     = '0;
  logic       busy;
  logic       done;
  logic [6:0] inv_out;
  logic       zero_div;

  int unsigned n_cmp   = 0;
  int unsigned n_bad   = 0;
  int unsigned cyc_cnt = 0;

  typedef struct {
    logic [6:0] a;
    logic [6:0] inv;
    logic       zd;
    bit         inject;
  } vec_t;

  vec_t vecs [6];

  gf7_inverter_seq #(.FIELD_W(7), .FIELD_POLY(8'h83)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .a_in     (a_in),
    .busy     (busy),
    .done     (done),
    .inv_out  (inv_out),
    .zero_div (zero_div)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Schoolbook carry-less product, then reduce high bits by x^7+x+1
  function automatic logic [6:0] ref_mul(input logic [6:0] x, input logic [6:0] y);
    logic [12:0] p;
    p = '0;
    for (int i = 0; i < 7; i++)
      if (y[i]) p = p ^ (13'(x) << i);
    for (int k = 12; k >= 7; k--)
      if (p[k]) p = p ^ (13'h083 << (k - 7));
    return p[6:0];
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int unsigned cyc;
    int unsigned busy_n;
    bit          seen;
    bit          extra;
    @(negedge clk);
    a_in  = v.a;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    a_in   = 7'h2A;
    cyc    = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && cyc < 40) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_n++;
        start = (v.inject && (cyc == 3 || cyc == 10)) ? 1'b1 : 1'b0;
        if (start) a_in = 7'h7F;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, 32'(seen), 1);
    chk({nm, "_latency"}, cyc, 11);
    chk({nm, "_busy_cycles"}, busy_n, 11);
    chk({nm, "_busy_at_done"}, 32'(busy), 0);
    chk({nm, "_inv_out"}, 32'(inv_out), 32'(v.inv));
    chk({nm, "_zero_div"}, 32'(zero_div), 32'(v.zd));
    extra = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) extra = 1'b1;
    end
    chk({nm, "_no_extra_done"}, 32'(extra), 0);
    chk({nm, "_inv_held"}, 32'(inv_out), 32'(v.inv));
  endtask

  initial begin
    int unsigned prev;
    int unsigned w;
    bit          stray;

    vecs[0] = '{a: 7'h01, inv: 7'h01, zd: 1'b0, inject: 1'b0};
    vecs[1] = '{a: 7'h02, inv: 7'h41, zd: 1'b0, inject: 1'b0};
    vecs[2] = '{a: 7'h41, inv: 7'h02, zd: 1'b0, inject: 1'b0};
    vecs[3] = '{a: 7'h04, inv: 7'h61, zd: 1'b0, inject: 1'b0};
    vecs[4] = '{a: 7'h00, inv: 7'h00, zd: 1'b1, inject: 1'b0};
    vecs[5] = '{a: 7'h04, inv: 7'h61, zd: 1'b0, inject: 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_inv_out", 32'(inv_out), 0);
    chk("rst_zero_div", 32'(zero_div), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // All nonzero elements, each start issued in the previous DONE cycle
    @(negedge clk);
    a_in  = 7'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev  = cyc_cnt;
    for (int unsigned v = 1; v <= 127; v++) begin
      w = 0;
      while (!done && w < 40) begin
        @(negedge clk);
        w++;
      end
      chk("sweep_done", 32'(done), 1);
      if (!done) break;
      chk("sweep_product", 32'(ref_mul(inv_out, 7'(v))), 1);
      chk("sweep_zero_div", 32'(zero_div), 0);
      chk("sweep_spacing", cyc_cnt - prev, (v == 1) ? 11 : 12);
      prev = cyc_cnt;
      if (v < 127) begin
        a_in  = 7'(v + 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end

    // Abort mid-run; start held during the reset cycle must be ignored
    @(negedge clk);
    a_in  = 7'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 1);
    reset_n = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_inv_out", 32'(inv_out), 0);
    chk("abort_zero_div", 32'(zero_div), 0);
    reset_n = 1'b1;
    start   = 1'b0;
    stray   = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) stray = 1'b1;
    end
    chk("abort_no_done", 32'(stray), 0);
    run_vec('{a: 7'h02, inv: 7'h41, zd: 1'b0, inject: 1'b0}, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
